// File: rtl/intc_cpu_if.sv
// intc_cpu_if: CPU-side interrupt handshake (request, preempt, acknowledge, holdoff).
// Define INTC_CPU_IF_TIMEOUT_EN to build the sticky unacknowledged-request timeout.
module intc_cpu_if #(
  parameter int HOLDOFF   = 3,
  parameter int TO_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sl_req_i,
  input  logic [4:0] sl_level_i,
  input  logic [7:0] sl_vec_i,
  input  logic [3:0] cpu_mask_i,
  input  logic       cpu_ack_i,
  output logic       int_req_o,
  output logic [4:0] int_level_o,
  output logic [7:0] int_vec_o,
  output logic       cp_intack_all_o,
  output logic [7:0] ack_vec_o,
  output logic       to_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       elig;
  // NMI (16) and error (17) levels bypass the CPU mask
  assign elig = sl_req_i && (sl_level_i >= 5'd16 || sl_level_i > {1'b0, cpu_mask_i});
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      int_req_o       <= 1'b0;
      int_level_o     <= 5'd0;
      int_vec_o       <= 8'd0;
      cp_intack_all_o <= 1'b0;
      ack_vec_o       <= 8'd0;
    end else begin
      cp_intack_all_o <= 1'b0;
      case (state)
        IDLE: if (elig) begin
          state       <= REQ;
          int_req_o   <= 1'b1;
          int_level_o <= sl_level_i;
          int_vec_o   <= sl_vec_i;
        end
        REQ: if (cpu_ack_i) begin
          state           <= ACK;
          int_req_o       <= 1'b0;
          cp_intack_all_o <= 1'b1;
          ack_vec_o       <= int_vec_o;
        end else if (!elig) begin
          state     <= IDLE;
          int_req_o <= 1'b0;
        end else if (sl_level_i > int_level_o) begin
          int_level_o <= sl_level_i;
          int_vec_o   <= sl_vec_i;
        end
        ACK: begin
          state <= HOLD;
          cnt   <= 4'(HOLDOFF);
        end
        default: begin
          cnt   <= cnt - 4'd1;
          state <= cnt == 4'd1 ? IDLE : HOLD;
        end
      endcase
    end
`ifdef INTC_CPU_IF_TIMEOUT_EN
  logic [10:0] to_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      to_cnt   <= 11'd0;
      to_err_o <= 1'b0;
    end else begin
      to_cnt <= state == REQ ? to_cnt + 11'd1 : 11'd0;
      if (state == REQ && to_cnt + 11'd1 == 11'(TO_CYCLES)) to_err_o <= 1'b1;
    end
`else
  assign to_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_intc_cpu_if.sv
// tb_intc_cpu_if: directed handshake scenarios against a cycle-level behavioural model.
module tb_intc_cpu_if;
  localparam int HO = 3;
  localparam int TO = 16;
`ifdef INTC_CPU_IF_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  logic       clk = 1'b0, rst = 1'b1, sl_req = 1'b0, ack = 1'b0;
  logic [4:0] sl_level = 5'd0;
  logic [7:0] sl_vec = 8'd0;
  logic [3:0] mask = 4'd0;
  logic       int_req, pulse, to_err;
  logic [4:0] int_level;
  logic [7:0] int_vec, ack_vec;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  intc_cpu_if #(.HOLDOFF(HO), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .sl_req_i(sl_req), .sl_level_i(sl_level), .sl_vec_i(sl_vec),
    .cpu_mask_i(mask), .cpu_ack_i(ack), .int_req_o(int_req), .int_level_o(int_level),
    .int_vec_o(int_vec), .cp_intack_all_o(pulse), .ack_vec_o(ack_vec), .to_err_o(to_err)
  );
  logic       m_req = 1'b0, m_pulse = 1'b0, m_err = 1'b0;
  logic [4:0] m_lvl = 5'd0;
  logic [7:0] m_vec = 8'd0, m_avec = 8'd0;
  int         quiet = 0, inreq = 0;
  function automatic bit elig();
    return sl_req && (sl_level >= 5'd16 || sl_level > {1'b0, mask});
  endfunction
  // quiet counts the ack cycle plus holdoff cycles during which nothing is accepted
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_req = 0; m_pulse = 0; m_err = 0; m_lvl = 0; m_vec = 0; m_avec = 0; quiet = 0; inreq = 0;
    end else begin
      m_pulse = 0;
      if (m_req) begin
        inreq++;
        if (TO_ON && inreq == TO) m_err = 1;
      end else inreq = 0;
      if (quiet > 0) quiet--;
      else if (!m_req) begin
        if (elig()) begin m_req = 1; m_lvl = sl_level; m_vec = sl_vec; end
      end else if (ack) begin
        m_req = 0; m_avec = m_vec; m_pulse = 1; quiet = HO + 1;
      end else if (!elig()) m_req = 0;
      else if (sl_level > m_lvl) begin m_lvl = sl_level; m_vec = sl_vec; end
    end
  always @(negedge clk) begin
    total++;
    if ({int_req, int_level, int_vec, pulse, ack_vec, to_err} ===
        {m_req, m_lvl, m_vec, m_pulse, m_avec, m_err}) passed++;
    else $display("FAIL model t=%0t got req=%b lvl=%0d vec=%h ack=%b avec=%h err=%b want req=%b lvl=%0d vec=%h ack=%b avec=%h err=%b",
                  $time, int_req, int_level, int_vec, pulse, ack_vec, to_err,
                  m_req, m_lvl, m_vec, m_pulse, m_avec, m_err);
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h want=%h", n, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic [4:0] l, input logic [7:0] v);
    sl_req = r; sl_level = l; sl_vec = v;
  endtask
  initial begin
    #1 rst = 1'b0;
    #1 chk("reset_outputs", {int_req, int_level, int_vec, pulse, ack_vec, to_err}, 0);
    tick(2);
    rst = 1'b1;
    mask = 4'd3; drive(1, 5'd5, 8'h40);
    tick(1); chk("first_req", {int_req, int_level, int_vec}, {1'b1, 5'd5, 8'h40});
    ack = 1;
    tick(1); ack = 0;
    chk("ack_pulse", {pulse, ack_vec, int_req}, {1'b1, 8'h40, 1'b0});
    ack = 1;
    tick(1); ack = 0;
    chk("hold1_ack_ignored", {pulse, int_req, ack_vec}, {1'b0, 1'b0, 8'h40});
    tick(2); chk("hold3_req_low", int_req, 0);
    tick(1); chk("idle_req_low", int_req, 0);
    tick(1); chk("rerequest", int_req, 1);
    sl_req = 0;
    tick(1); chk("withdraw", {int_req, pulse}, 0);
    mask = 4'd7; drive(1, 5'd5, 8'h41);
    tick(2); chk("masked", int_req, 0);
    drive(1, 5'd16, 8'h0B);
    tick(1); chk("nmi", {int_req, int_level, int_vec}, {1'b1, 5'd16, 8'h0B});
    sl_req = 0;
    tick(1);
    mask = 4'd3; drive(1, 5'd5, 8'h40);
    tick(1); chk("pre_base", int_vec, 8'h40);
    drive(1, 5'd9, 8'h48);
    tick(1); chk("preempt", {int_req, int_level, int_vec}, {1'b1, 5'd9, 8'h48});
    drive(1, 5'd12, 8'h4C); ack = 1;
    tick(1); ack = 0;
    chk("ack_beats_preempt", {pulse, ack_vec, int_vec}, {1'b1, 8'h48, 8'h48});
    sl_req = 0;
    tick(6);
    mask = 4'd0; drive(1, 5'd3, 8'h33);
    tick(16); chk("to_before", to_err, 0);
    tick(1); chk("to_at_limit", to_err, 32'(TO_ON));
    ack = 1;
    tick(1); ack = 0;
    chk("to_sticky", {pulse, to_err}, {1'b1, TO_ON});
    sl_req = 0;
    tick(6);
    mask = 4'd3; drive(1, 5'd5, 8'h40);
    tick(1); ack = 1;
    tick(1); ack = 0;
    chk("pre_reset_ack", pulse, 1);
    #2 rst = 1'b0;
    #1 chk("async_reset", {int_req, int_level, int_vec, pulse, ack_vec, to_err}, 0);
    sl_req = 0;
    tick(2); rst = 1'b1;
    tick(3); chk("no_pulse_after_reset", {pulse, int_req}, 0);
    tick(1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/intc_cpu_if.md
INTC_CPU_IF -- requirements
Module: intc_cpu_if

Interface
REQ-001 Parameter HOLDOFF, default 3, SHALL set the number of cycles after an acknowledge during which new requests are ignored (range 1..15).
REQ-002 Parameter TO_CYCLES, default 1024, SHALL set the unacknowledged-request timeout in cycles; used only with INTC_CPU_IF_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-005 sl_req_i  input  1  selected request from the interrupt selection stage.
REQ-006 sl_level_i  input  5  level of selected request; 0 = none, 1..15 maskable, 16 = NMI, 17 = error.
REQ-007 sl_vec_i  input  8  vector of selected request.
REQ-008 cpu_mask_i  input  4  CPU current interrupt mask (SR.I).
REQ-009 cpu_ack_i  input  1  CPU accept strobe, one-cycle pulse.
REQ-010 int_req_o  output  1  interrupt request to CPU.
REQ-011 int_level_o  output  5  level presented to CPU.
REQ-012 int_vec_o  output  8  vector presented to CPU.
REQ-013 cp_intack_all_o  output  1  one-cycle acknowledge pulse back to the selection stage.
REQ-014 ack_vec_o  output  8  vector of last accepted interrupt, held until next accept.
REQ-015 to_err_o  output  1  sticky timeout flag (tied 0 without INTC_CPU_IF_TIMEOUT_EN).

Function
REQ-016 A request SHALL be eligible when sl_req_i=1 and (sl_level_i>=16 or sl_level_i>cpu_mask_i zero-extended to 5 bits).
REQ-017 FSM states SHALL be IDLE, REQ, ACK, HOLD; encoding free.
REQ-018 IDLE: on eligible request, register sl_level_i/sl_vec_i into int_level_o/int_vec_o and go to REQ next cycle; int_req_o=1 from that cycle (latency 1).
REQ-019 REQ: int_req_o SHALL be 1; if an eligible request with sl_level_i greater than int_level_o arrives, int_level_o/int_vec_o SHALL update next cycle (preemption) without dropping int_req_o.
REQ-020 REQ: if the request becomes ineligible (sl_req_i=0 or mask raised) and cpu_ack_i=0, return to IDLE and drop int_req_o next cycle.
REQ-021 REQ with cpu_ack_i=1: go to ACK; ack_vec_o SHALL capture current int_vec_o; cpu_ack_i has priority over withdrawal and preemption in the same cycle.
REQ-022 ACK (exactly one cycle): cp_intack_all_o=1, int_req_o=0; then HOLD.
REQ-023 HOLD: int_req_o=0, cpu_ack_i and sl_req_i ignored for HOLDOFF cycles (4-bit down-counter), then IDLE.
REQ-024 cpu_ack_i outside REQ SHALL be ignored; no pulse, ack_vec_o unchanged.
REQ-025 cp_intack_all_o SHALL never be asserted two consecutive cycles.
REQ-026 int_level_o/int_vec_o SHALL hold their last value in IDLE/ACK/HOLD.

Reset
REQ-027 rst=0 SHALL asynchronously force state IDLE, HOLD counter 0, int_req_o=0, int_level_o=0, int_vec_o=0, cp_intack_all_o=0, ack_vec_o=0, to_err_o=0, timeout counter 0.
REQ-028 Reset mid-handshake (any state) SHALL abandon the request; no acknowledge pulse is emitted after release.
REQ-029 First eligible request SHALL be accepted on the first rising edge with rst=1.

Configuration
REQ-030 Macro INTC_CPU_IF_TIMEOUT_EN defined: an 11-bit counter SHALL increment each cycle in REQ, clear on leaving REQ, and at TO_CYCLES set to_err_o=1 (sticky until reset) without altering the FSM.
REQ-031 Macro undefined: no counter SHALL be built and to_err_o SHALL be constant 0.

Verification
REQ-032 Mask=3, sl_req_i=1 level 5 vec 0x40 -> int_req_o=1 next cycle, level 5, vec 0x40; ack pulse -> cp_intack_all_o=1 one cycle, ack_vec_o=0x40, int_req_o=0 for 1+3 cycles.
REQ-033 Mask=7, level 5 request -> no int_req_o; level 16 vec 0x0B -> int_req_o=1 with level 16.
REQ-034 In REQ at level 5 vec 0x40, level 9 vec 0x48 arrives -> int_vec_o=0x48 next cycle, int_req_o stays 1; ack same cycle as level-12 arrival -> ack_vec_o=0x48.
REQ-035 In REQ, sl_req_i drops with no ack -> int_req_o=0 next cycle, no cp_intack_all_o; ack during HOLD -> ignored.
REQ-036 rst=0 asserted mid-ACK -> all outputs 0 immediately, no pulse after release.
REQ-037 With INTC_CPU_IF_TIMEOUT_EN, TO_CYCLES=16, request held unacked 16 cycles -> to_err_o=1 and stays 1 after ack; without macro -> to_err_o=0.
